fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-flow controller for the processor core. Owns the program counter and a small return-address stack.
- Runs the fetch/decode/execute cycle: fetches from instruction memory over a req/ack handshake, holds the instruction in an IR, and hands the instruction to the external decoder and ALU.
- Resolves the next PC: sequential, jump, conditional branch, call, return or halt.
- Sits between instruction memory, the decoder and the execute datapath.

Parameters:
- ADDR_WIDTH, 8, program counter and memory address width.
- INSTR_WIDTH, 16, instruction word width.
- STACK_DEPTH, 4, number of return-address stack entries (at least 1).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  ADDR_WIDTH  fetch address; always equals pc.
- mem_ack  in  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  in  INSTR_WIDTH  fetched instruction word.
- ir  out  INSTR_WIDTH  instruction register, feeds the decoder.
- dec_kind  in  3  decoded class: 0 ALU, 1 JMP, 2 BRZ, 3 CALL, 4 RET, 5 HALT, 6–7 illegal.
- dec_target  in  ADDR_WIDTH  jump/branch/call target.
- cond  in  1  zero flag for BRZ.
- exec_start  out  1  one-cycle pulse that starts the datapath operation.
- exec_done  in  1  datapath operation complete.
- resume  in  1  leave the HALT state.
- pc  out  ADDR_WIDTH  current program counter.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE, pc=RESET_VECTOR, ir=0, stack pointer sp=0, stack contents don't-care.
  - mem_req=0, exec_start=0, halted=0, fault=0.
  - Reset mid-operation aborts everything immediately; an outstanding fetch is dropped, and a late mem_ack is ignored.
- States: IDLE, FETCH, DECODE, EXEC, HALT, FAULT. mem_req, halted and fault are decoded from state only. mem_addr=pc at all times.
- IDLE: moves to FETCH on the next cycle after reset release.
- FETCH:
  - mem_req=1.
  - On a cycle with mem_ack=1: ir<=mem_rdata, go to DECODE.
  - Otherwise stay; wait states are unbounded.
  - mem_ack outside FETCH is ignored.
- DECODE: exactly one cycle. Acts on dec_kind, which is combinational from ir, sampled this cycle:
  - 0 ALU: go to EXEC, with exec_start=1 registered so it is high on the first EXEC cycle only.
  - 1 JMP: pc<=dec_target, go to FETCH.
  - 2 BRZ: pc<=cond ? dec_target : pc+1, go to FETCH.
  - 3 CALL:
    - If sp==STACK_DEPTH, go to FAULT with pc unchanged.
    - Otherwise stack[sp]<=pc+1, sp<=sp+1, pc<=dec_target, go to FETCH.
  - 4 RET:
    - If sp==0, go to FAULT with pc unchanged.
    - Otherwise sp<=sp-1, pc<=stack[sp-1], go to FETCH.
  - 5 HALT: pc<=pc+1, go to HALT.
  - 6, 7: go to FAULT with pc unchanged.
- EXEC:
  - Wait for exec_done, which may arrive in the same cycle as exec_start.
  - On exec_done: pc<=pc+1, go to FETCH.
  - exec_done is ignored in all other states.
- HALT: halted=1. When resume=1, go to FETCH. resume is ignored in other states.
- FAULT: sticky; fault=1. Leaves only through reset.
- Arithmetic:
  - pc+1 wraps modulo 2^ADDR_WIDTH, so a CALL at the maximum address pushes 0.
  - sp width is clog2(STACK_DEPTH+1).
- Throughput without wait states:
  - JMP/BRZ/CALL/RET/HALT: 2 cycles per instruction.
  - ALU with same-cycle exec_done: 3 cycles per instruction.

Test Plan:
- Reset and straight-line ALU:
  - Stimulus: RESET_VECTOR=0; memory acks in the same cycle; exec_done tied high.
  - Required: mem_req rises 1 cycle after rst deasserts; pc steps 0,1,2; exec_start pulses once per instruction; each instruction takes 3 cycles.
- Fetch wait states and reset mid-fetch:
  - Delay mem_ack by 3 cycles → mem_req stays high and pc is stable through the wait.
  - Assert rst while in FETCH → mem_req=0 immediately and pc=0.
- Branch:
  - BRZ with target 0x40 at pc=5, cond=1 → pc=0x40.
  - Same BRZ with cond=0 → pc=6.
  - JMP with target 0xFF, then an ALU instruction → pc wraps to 0x00.
- Call/return and stack limits (STACK_DEPTH=4):
  - CALL at pc=0x10 with target 0x80 → pc=0x80; a later RET → pc=0x11.
  - Five nested CALLs → fault=1 on the fifth, pc holds the fifth CALL's address.
  - RET with an empty stack → fault=1.
- HALT, resume and illegal opcode:
  - HALT at pc=7 → halted=1 and pc=8; resume=1 → FETCH at 8.
  - dec_kind=6 → fault=1, sticky until rst.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory, decoder and execute handshake bundle for the fetch sequencer
interface fetch_sequencer_if #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 16
);
   logic                   mem_req;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic                   mem_ack;
   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic [INSTR_WIDTH-1:0] ir;
   logic [2:0]             dec_kind;
   logic [ADDR_WIDTH-1:0]  dec_target;
   logic                   cond;
   logic                   exec_start;
   logic                   exec_done;

   modport master (
      output mem_req, mem_addr, ir, exec_start,
      input  mem_ack, mem_rdata, dec_kind, dec_target, cond, exec_done
   );

   modport slave (
      input  mem_req, mem_addr, ir, exec_start,
      output mem_ack, mem_rdata, dec_kind, dec_target, cond, exec_done
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, return-address stack and fetch/decode/execute sequencing
module fetch_sequencer #(
   parameter int                    ADDR_WIDTH   = 8,
   parameter int                    INSTR_WIDTH  = 16,
   parameter int                    STACK_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_sequencer_if.master     bus,
   input  logic                  resume,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted,
   output logic                  fault
);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   // Stack storage is rounded up to a power of two so every index value is in range;
   // the full/empty guards keep accesses within the first STACK_DEPTH entries.
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   localparam logic [2:0] K_ALU  = 3'd0;
   localparam logic [2:0] K_JMP  = 3'd1;
   localparam logic [2:0] K_BRZ  = 3'd2;
   localparam logic [2:0] K_CALL = 3'd3;
   localparam logic [2:0] K_RET  = 3'd4;
   localparam logic [2:0] K_HALT = 3'd5;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT, FAULT} state_t;

   state_t                 state, state_next;
   logic [ADDR_WIDTH-1:0]  pc_next, pc_inc, ret_addr;
   logic [SP_W-1:0]        sp, sp_next;
   logic [IDX_W-1:0]       push_idx, top_idx;
   logic [INSTR_WIDTH-1:0] ir_q;
   logic                   exec_start_q, exec_start_next, push;
   logic [ADDR_WIDTH-1:0]  stack [2**IDX_W];

   assign pc_inc   = pc + ADDR_WIDTH'(1);
   assign push_idx = sp[IDX_W-1:0];
   assign top_idx  = push_idx - IDX_W'(1);
   assign ret_addr = stack[top_idx];

   assign bus.mem_req    = (state == FETCH);
   assign bus.mem_addr   = pc;
   assign bus.ir         = ir_q;
   assign bus.exec_start = exec_start_q;
   assign halted         = (state == HALT);
   assign fault          = (state == FAULT);

   // Next-state, next-PC and stack-pointer resolution for the instruction cycle
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      sp_next         = sp;
      push            = 1'b0;
      exec_start_next = 1'b0;
      case (state)
         IDLE:   state_next = FETCH;
         FETCH:  if (bus.mem_ack) state_next = DECODE;
         DECODE: begin
            case (bus.dec_kind)
               K_ALU: begin
                  state_next      = EXEC;
                  exec_start_next = 1'b1;
               end
               K_JMP: begin
                  pc_next    = bus.dec_target;
                  state_next = FETCH;
               end
               K_BRZ: begin
                  pc_next    = bus.cond ? bus.dec_target : pc_inc;
                  state_next = FETCH;
               end
               K_CALL: begin
                  if (sp == SP_FULL) begin
                     state_next = FAULT;
                  end else begin
                     push       = 1'b1;
                     sp_next    = sp + SP_W'(1);
                     pc_next    = bus.dec_target;
                     state_next = FETCH;
                  end
               end
               K_RET: begin
                  if (sp == '0) begin
                     state_next = FAULT;
                  end else begin
                     sp_next    = sp - SP_W'(1);
                     pc_next    = ret_addr;
                     state_next = FETCH;
                  end
               end
               K_HALT: begin
                  pc_next    = pc_inc;
                  state_next = HALT;
               end
               default: state_next = FAULT;
            endcase
         end
         EXEC: begin
            if (bus.exec_done) begin
               pc_next    = pc_inc;
               state_next = FETCH;
            end
         end
         HALT:    if (resume) state_next = FETCH;
         FAULT:   state_next = FAULT;
         default: state_next = FAULT;
      endcase
   end

   // State, PC, stack pointer, IR and the exec_start pulse register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pc           <= RESET_VECTOR;
         sp           <= '0;
         ir_q         <= '0;
         exec_start_q <= 1'b0;
      end else begin
         state        <= state_next;
         pc           <= pc_next;
         sp           <= sp_next;
         exec_start_q <= exec_start_next;
         if (state == FETCH && bus.mem_ack) ir_q <= bus.mem_rdata;
      end
   end

   // Return-address storage; contents are meaningless after reset so it carries no reset
   always_ff @(posedge clk) begin
      if (push) stack[push_idx] <= pc_inc;
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for the fetch sequencer
module tb_fetch_sequencer;
   typedef struct {
      logic [7:0] addr;
      int         gap;
   } fetch_t;

   logic       clk;
   logic       rst;
   logic       resume;
   logic [7:0] pc;
   logic       halted;
   logic       fault;

   fetch_sequencer_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();

   fetch_sequencer #(
      .ADDR_WIDTH(8), .INSTR_WIDTH(16), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .resume(resume),
      .pc(pc), .halted(halted), .fault(fault)
   );

   // Decoder stand-in: kind in the top three bits, target in the low byte
   assign bus.dec_kind   = bus.ir[15:13];
   assign bus.dec_target = bus.ir[7:0];

   logic [15:0] mem [256];
   fetch_t      sb [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cycle = 0;
   int          last_hs = 0;
   int          wait_cnt = 0;
   int          wait_states = 0;
   int          exec_delay = 0;
   int          ed_cnt = 0;
   int          n_exec = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ins(input logic [2:0] k, input logic [7:0] t);
      return {k, 5'd0, t};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_fetch(input logic [7:0] a, input int g);
      fetch_t e;
      e.addr = a;
      e.gap  = g;
      sb.push_back(e);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   // One cycle: sample at negedge, score any fetch that is about to complete, drive next inputs
   task automatic tick();
      fetch_t e;
      @(negedge clk);
      cycle++;
      if (bus.exec_start) n_exec++;
      if (bus.exec_start) ed_cnt = exec_delay;
      else if (ed_cnt > 0) ed_cnt--;
      bus.exec_done = (ed_cnt == 0);
      if (bus.mem_req && sb.size() > 0) begin
         if (wait_cnt >= wait_states) begin
            e = sb.pop_front();
            check_eq("fetch_addr", {24'd0, bus.mem_addr}, {24'd0, e.addr});
            if (e.gap != 0) check_eq("fetch_gap", cycle - last_hs, e.gap);
            last_hs       = cycle;
            wait_cnt      = 0;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr];
         end else begin
            check_eq("wait_pc", {24'd0, bus.mem_addr}, {24'd0, sb[0].addr});
            wait_cnt++;
            bus.mem_ack = 1'b0;
         end
      end else begin
         bus.mem_ack = 1'b0;
      end
   endtask

   task automatic check_reset();
      check_eq("rst_pc", {24'd0, pc}, 32'h00);
      check_eq("rst_ir", {16'd0, bus.ir}, 32'h0);
      check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("rst_exec_start", {31'd0, bus.exec_start}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_fault", {31'd0, fault}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sb.delete();
      wait_cnt = 0;
      wait_states = 0;
      exec_delay = 0;
      ed_cnt = 0;
      n_exec = 0;
      resume = 1'b0;
      bus.cond = 1'b0;
      tick();
      check_reset();
      tick();
      rst = 1'b1;
      last_hs = cycle;
   endtask

   task automatic run_fetches(input int max_cycles);
      int n;
      n = 0;
      while (sb.size() > 0 && n < max_cycles) begin
         tick();
         n++;
      end
      if (sb.size() > 0) check_eq("fetch_timeout", sb.size(), 0);
   endtask

   task automatic settle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      rst = 1'b0;
      resume = 1'b0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 16'h0;
      bus.cond = 1'b0;
      bus.exec_done = 1'b1;

      // Straight-line ALU: first fetch one cycle after release, then 3 cycles each
      clear_mem();
      mem[3] = 16'h1234;
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'h01, 3);
      push_fetch(8'h02, 3);
      push_fetch(8'h03, 3);
      run_fetches(100);
      settle(3);
      check_eq("alu_pc", {24'd0, pc}, 32'h04);
      check_eq("alu_exec_starts", n_exec, 4);
      check_eq("alu_ir", {16'd0, bus.ir}, 32'h1234);
      check_eq("alu_mem_req", {31'd0, bus.mem_req}, 32'd1);

      // Slow datapath: exec_done two cycles after exec_start
      clear_mem();
      do_reset();
      exec_delay = 2;
      push_fetch(8'h00, 1);
      push_fetch(8'h01, 5);
      run_fetches(100);
      settle(6);
      check_eq("slow_exec_pc", {24'd0, pc}, 32'h02);
      check_eq("slow_exec_starts", n_exec, 2);

      // Fetch wait states, then reset while a fetch is outstanding
      clear_mem();
      do_reset();
      wait_states = 3;
      push_fetch(8'h00, 4);
      push_fetch(8'h01, 6);
      run_fetches(100);
      push_fetch(8'h02, 0);
      settle(4);
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 16'hA5A5;
      #1;
      check_eq("midfetch_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("midfetch_pc", {24'd0, pc}, 32'h00);
      @(negedge clk);
      check_eq("midfetch_ir", {16'd0, bus.ir}, 32'h0);
      rst = 1'b1;
      sb.delete();
      wait_cnt = 0;
      wait_states = 0;
      push_fetch(8'h00, 0);
      tick();
      check_eq("late_ack_ir", {16'd0, bus.ir}, 32'h0);
      settle(3);
      check_eq("after_midfetch_pc", {24'd0, pc}, 32'h01);

      // BRZ taken and not taken
      for (int c = 1; c >= 0; c--) begin
         clear_mem();
         mem[8'h00] = ins(3'd1, 8'h05);
         mem[8'h05] = ins(3'd2, 8'h40);
         do_reset();
         bus.cond = c[0];
         push_fetch(8'h00, 1);
         push_fetch(8'h05, 2);
         push_fetch(c[0] ? 8'h40 : 8'h06, 2);
         run_fetches(100);
      end

      // JMP to the top address and wrap on the following ALU
      clear_mem();
      mem[8'h00] = ins(3'd1, 8'hFF);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'hFF, 2);
      push_fetch(8'h00, 3);
      run_fetches(100);

      // CALL then RET
      clear_mem();
      mem[8'h00] = ins(3'd1, 8'h10);
      mem[8'h10] = ins(3'd3, 8'h80);
      mem[8'h80] = ins(3'd4, 8'h00);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'h10, 2);
      push_fetch(8'h80, 2);
      push_fetch(8'h11, 2);
      run_fetches(100);
      settle(3);
      check_eq("callret_pc", {24'd0, pc}, 32'h12);
      check_eq("callret_fault", {31'd0, fault}, 32'd0);

      // CALL from the top address pushes a wrapped return address
      clear_mem();
      mem[8'h00] = ins(3'd1, 8'hFF);
      mem[8'hFF] = ins(3'd3, 8'h80);
      mem[8'h80] = ins(3'd4, 8'h00);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'hFF, 2);
      push_fetch(8'h80, 2);
      push_fetch(8'h00, 2);
      run_fetches(100);

      // Five nested CALLs overflow a four-entry stack
      clear_mem();
      mem[8'h00] = ins(3'd3, 8'h20);
      mem[8'h20] = ins(3'd3, 8'h30);
      mem[8'h30] = ins(3'd3, 8'h40);
      mem[8'h40] = ins(3'd3, 8'h50);
      mem[8'h50] = ins(3'd3, 8'h60);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'h20, 2);
      push_fetch(8'h30, 2);
      push_fetch(8'h40, 2);
      push_fetch(8'h50, 2);
      run_fetches(100);
      settle(3);
      check_eq("overflow_fault", {31'd0, fault}, 32'd1);
      check_eq("overflow_pc", {24'd0, pc}, 32'h50);
      check_eq("overflow_mem_req", {31'd0, bus.mem_req}, 32'd0);

      // RET with an empty stack
      clear_mem();
      mem[8'h00] = ins(3'd1, 8'h03);
      mem[8'h03] = ins(3'd4, 8'h00);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'h03, 2);
      run_fetches(100);
      settle(3);
      check_eq("underflow_fault", {31'd0, fault}, 32'd1);
      check_eq("underflow_pc", {24'd0, pc}, 32'h03);

      // HALT then resume
      clear_mem();
      mem[8'h00] = ins(3'd1, 8'h07);
      mem[8'h07] = ins(3'd5, 8'h00);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'h07, 2);
      run_fetches(100);
      settle(3);
      check_eq("halt_halted", {31'd0, halted}, 32'd1);
      check_eq("halt_pc", {24'd0, pc}, 32'h08);
      check_eq("halt_mem_req", {31'd0, bus.mem_req}, 32'd0);
      push_fetch(8'h08, 0);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check_eq("resume_fetched", sb.size(), 0);
      settle(4);
      check_eq("resume_halted", {31'd0, halted}, 32'd0);
      check_eq("resume_pc", {24'd0, pc}, 32'h09);

      // Illegal kind faults and stays faulted even with resume asserted
      clear_mem();
      mem[8'h00] = ins(3'd1, 8'h04);
      mem[8'h04] = ins(3'd6, 8'h00);
      do_reset();
      push_fetch(8'h00, 1);
      push_fetch(8'h04, 2);
      run_fetches(100);
      settle(3);
      check_eq("illegal_fault", {31'd0, fault}, 32'd1);
      check_eq("illegal_pc", {24'd0, pc}, 32'h04);
      resume = 1'b1;
      settle(8);
      resume = 1'b0;
      check_eq("sticky_fault", {31'd0, fault}, 32'd1);
      check_eq("sticky_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("sticky_pc", {24'd0, pc}, 32'h04);
      do_reset();
      settle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
